// File: rtl/gift_dec_keysch_ctrl_if.sv
// Interface bundling the controller's key input, key-schedule register side
// and round-key memory write port.
interface gift_dec_keysch_ctrl_if #(
   parameter int unsigned ADDR_W = 6
);
   logic              inStart;
   logic [127:0]      inKey;
   logic [127:0]      inRegData;
   logic [5:0]        inRegRoundConst;
   logic [135:0]      inRegDataToMem;
   logic              outRegExtWr;
   logic [127:0]      outRegExtData;
   logic              outRegIntWr;
   logic [127:0]      outRegIntData;
   logic [5:0]        outRegIntRoundConst;
   logic              outMemWr;
   logic [ADDR_W-1:0] outMemAddr;
   logic [135:0]      outMemData;
   logic              outBusy;
   logic              outKeyValid;

   modport master (
      input  inStart, inKey, inRegData, inRegRoundConst, inRegDataToMem,
      output outRegExtWr, outRegExtData, outRegIntWr, outRegIntData,
             outRegIntRoundConst, outMemWr, outMemAddr, outMemData,
             outBusy, outKeyValid
   );

   modport slave (
      output inStart, inKey, inRegData, inRegRoundConst, inRegDataToMem,
      input  outRegExtWr, outRegExtData, outRegIntWr, outRegIntData,
             outRegIntRoundConst, outMemWr, outMemAddr, outMemData,
             outBusy, outKeyValid
   );
endinterface

// File: rtl/gift_dec_keysch_ctrl.sv
// GIFT-128 decryption key-schedule sequencer: loads the master key into the
// external schedule register, then writes one round-key word per cycle.
module gift_dec_keysch_ctrl #(
   parameter int unsigned NUM_ROUNDS = 40,
   parameter int unsigned ADDR_W     = 6
) (
   input  logic                   inClk,
   input  logic                   inRst,
   gift_dec_keysch_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_EXPAND,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ROUND = ADDR_W'(NUM_ROUNDS - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              key_valid_q, key_valid_d;

   logic              accept;
   logic              expanding;
   logic [15:0]       k [8];
   logic [127:0]      next_key;
   logic [5:0]        next_const;

   // Start is honoured only while idle or done; reset masks it so every
   // output reads zero while inRst is high.
   assign accept    = !inRst && bus.inStart && (state_q == S_IDLE || state_q == S_DONE);
   assign expanding = (state_q == S_EXPAND);

   always_comb begin
      for (int unsigned i = 0; i < 8; i++) begin
         k[i] = bus.inRegData[16*i +: 16];
      end
      next_key   = {k[1][1:0], k[1][15:2], k[0][11:0], k[0][15:12],
                    k[7], k[6], k[5], k[4], k[3], k[2]};
      next_const = {bus.inRegRoundConst[4:0],
                    bus.inRegRoundConst[5] ^ bus.inRegRoundConst[4] ^ 1'b1};
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      key_valid_d = key_valid_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               state_d     = S_LOAD;
               busy_d      = 1'b1;
               key_valid_d = 1'b0;
            end
         end
         S_LOAD: begin
            cnt_d   = '0;
            state_d = S_EXPAND;
         end
         S_EXPAND: begin
            if (cnt_q == LAST_ROUND) begin
               state_d     = S_DONE;
               busy_d      = 1'b0;
               key_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge inClk or posedge inRst) begin
      if (inRst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         key_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         key_valid_q <= key_valid_d;
      end
   end

   always_comb begin
      bus.outRegExtWr         = accept;
      bus.outRegExtData       = accept ? bus.inKey : '0;
      bus.outRegIntWr         = expanding;
      bus.outRegIntData       = expanding ? next_key : '0;
      bus.outRegIntRoundConst = expanding ? next_const : '0;
      bus.outMemWr            = expanding;
      bus.outMemAddr          = expanding ? cnt_q : '0;
      bus.outMemData          = expanding ? bus.inRegDataToMem : '0;
      bus.outBusy             = busy_q;
      bus.outKeyValid         = key_valid_q;
   end

endmodule

// File: tb/tb_gift_dec_keysch_ctrl.sv
// Bench for gift_dec_keysch_ctrl: register stand-in, scoreboard of round-key
// writes from an independent key-schedule model, and per-cycle timing checks.
module tb_gift_dec_keysch_ctrl;

   localparam int unsigned NR = 40;
   localparam int unsigned AW = 6;

   logic inClk = 1'b0;
   logic inRst = 1'b1;
   always #5 inClk = ~inClk;

   gift_dec_keysch_ctrl_if #(.ADDR_W(AW)) bus ();

   gift_dec_keysch_ctrl #(.NUM_ROUNDS(NR), .ADDR_W(AW)) dut (
      .inClk (inClk),
      .inRst (inRst),
      .bus   (bus)
   );

   // Stand-in for the external key-schedule register.
   logic [127:0] reg_key;
   logic [5:0]   reg_c;
   always @(posedge inClk or posedge inRst) begin
      if (inRst) begin
         reg_key <= '0;
         reg_c   <= '0;
      end else if (bus.outRegExtWr) begin
         reg_key <= bus.outRegExtData;
         reg_c   <= 6'd1;
      end else if (bus.outRegIntWr) begin
         reg_key <= bus.outRegIntData;
         reg_c   <= bus.outRegIntRoundConst;
      end
   end
   assign bus.inRegData       = reg_key;
   assign bus.inRegRoundConst = reg_c;
   assign bus.inRegDataToMem  = {reg_key, 2'b00, reg_c};

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   logic [AW+135:0] exp_q[$];
   logic [135:0]    cap [NR];
   int              wr_cnt;

   // Reference schedule: rotate the eight 16-bit key words and step the 6-bit LFSR.
   function automatic logic [15:0] rotr16(input logic [15:0] x, input int n);
      return 16'((x >> n) | (x << (16 - n)));
   endfunction

   task automatic push_expected(input logic [127:0] key);
      logic [15:0] w [8];
      logic [15:0] nw [8];
      int c;
      for (int j = 0; j < 8; j++) w[j] = key[16*j +: 16];
      c = 1;
      for (int r = 0; r < int'(NR); r++) begin
         logic [127:0] kk;
         for (int j = 0; j < 8; j++) kk[16*j +: 16] = w[j];
         exp_q.push_back({AW'(r), kk, 2'b00, 6'(c)});
         for (int j = 0; j < 6; j++) nw[j] = w[j+2];
         nw[6] = rotr16(w[0], 12);
         nw[7] = rotr16(w[1], 2);
         w = nw;
         c = ((c * 2) % 64) + ((((c / 32) % 2) ^ ((c / 16) % 2) ^ 1));
      end
   endtask

   // Monitor: pop and compare every memory write.
   always @(negedge inClk) begin
      if (!inRst && bus.outMemWr) begin
         wr_cnt++;
         if (bus.outMemAddr < AW'(NR)) cap[bus.outMemAddr] = bus.outMemData;
         if (exp_q.size() == 0) begin
            check("unexpected_write", {bus.outMemAddr, bus.outMemData}, '0);
         end else begin
            logic [AW+135:0] e;
            e = exp_q.pop_front();
            check("mem_addr", 136'(bus.outMemAddr), 136'(e[AW+135:136]));
            check("mem_data", bus.outMemData, e[135:0]);
         end
      end
      if (!inRst && bus.outRegExtWr && bus.outRegIntWr)
         check("ext_int_exclusive", 136'(1), 136'(0));
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, 136'({bus.outRegExtWr, bus.outRegIntWr, bus.outMemWr,
                                 bus.outBusy, bus.outKeyValid}), '0);
      check({tag, "_memaddr"}, 136'(bus.outMemAddr), '0);
      check({tag, "_memdata"}, bus.outMemData, '0);
      check({tag, "_intdata"}, {2'b00, bus.outRegIntRoundConst, bus.outRegIntData}, '0);
      check({tag, "_extdata"}, 136'(bus.outRegExtData), '0);
   endtask

   // One expansion; abort_round>0 asserts reset mid-run at that round.
   task automatic run(input logic [127:0] key, input bit noise, input int abort_round);
      wr_cnt = 0;
      push_expected(key);
      @(negedge inClk);
      bus.inStart = 1'b1;
      bus.inKey   = key;
      #1;
      check("ext_wr_on_accept", 136'(bus.outRegExtWr), 136'(1));
      check("ext_data_on_accept", 136'(bus.outRegExtData), 136'(key));
      @(negedge inClk);
      bus.inStart = 1'b0;
      bus.inKey   = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 1; k <= int'(NR) + 3; k++) begin
         if (k > 1) @(negedge inClk);
         #1;
         check($sformatf("busy_c%0d", k), 136'(bus.outBusy), 136'(k <= int'(NR) + 1));
         check($sformatf("kvalid_c%0d", k), 136'(bus.outKeyValid), 136'(k >= int'(NR) + 2));
         check($sformatf("memwr_c%0d", k), 136'(bus.outMemWr),
               136'(k >= 2 && k <= int'(NR) + 1));
         check($sformatf("extwr_c%0d", k), 136'(bus.outRegExtWr), 136'(0));
         if (abort_round > 0 && k == abort_round + 2) begin
            #2 inRst = 1'b1;
            #1;
            check_all_zero("midrun_reset");
            exp_q.delete();
            @(negedge inClk);
            inRst = 1'b0;
            repeat (3) @(negedge inClk);
            check("after_abort_kvalid", 136'(bus.outKeyValid), '0);
            check("after_abort_writes", 136'(wr_cnt), 136'(abort_round + 1));
            return;
         end
         bus.inStart = (noise && k <= int'(NR)) ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.inKey   = {$urandom, $urandom, $urandom, $urandom};
      end
      check("queue_drained", 136'(exp_q.size()), '0);
      check("write_count", 136'(wr_cnt), 136'(NR));
   endtask

   logic [5:0] const_tbl [12] = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E,
                                  6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1E, 6'h3C};

   initial begin
      logic [127:0] rk;
      bus.inStart = 1'b0;
      bus.inKey   = '0;
      wr_cnt      = 0;
      repeat (2) @(negedge inClk);
      check_all_zero("reset");
      inRst = 1'b0;
      repeat (3) @(negedge inClk);
      check_all_zero("idle");

      run('0, 1'b0, 0);
      check("zero_addr0", cap[0], 136'h01);
      for (int i = 0; i < 12; i++)
         check($sformatf("zero_const%0d", i), 136'(cap[i][5:0]), 136'(const_tbl[i]));
      for (int i = 0; i < int'(NR); i++)
         check($sformatf("zero_keyfield%0d", i), 136'(cap[i][135:8]), '0);

      rk = 128'h0000_0000_0000_0000_0000_0000_0004_0001;
      run(rk, 1'b0, 0);
      check("rot_addr0_key", 136'(cap[0][135:8]), 136'(rk));
      check("rot_addr1", cap[1],
            {128'h0001_0010_0000_0000_0000_0000_0000_0000, 2'b00, 6'h03});

      run({$urandom, $urandom, $urandom, $urandom}, 1'b1, 0);
      run({$urandom, $urandom, $urandom, $urandom}, 1'b0, 17);
      run({$urandom, $urandom, $urandom, $urandom}, 1'b1, 0);
      run({$urandom, $urandom, $urandom, $urandom}, 1'b0, 0);

      repeat (2) @(negedge inClk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
